pio_mailbox_bridge: RTL and testbench



---
 rtl/pio_mailbox_pkg.sv | 24 ++
 rtl/pio_mailbox_bridge_if.sv | 18 +
 rtl/pio_handshake_channel.sv | 101 ++++++++++
 rtl/pio_mailbox_bridge.sv | 144 ++++++++++++++
 tb/tb_pio_mailbox_bridge.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pio_mailbox_pkg.sv
// Shared types and register offsets for the PIO mailbox bridge.
package pio_mailbox_pkg;

  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } chan_state_t;

  localparam logic [ADDR_W-1:0] KEY_BASE = 6'h00;
  localparam logic [ADDR_W-1:0] REQ_BASE = 6'h10;
  localparam logic [ADDR_W-1:0] GO       = 6'h20;
  localparam logic [ADDR_W-1:0] DONE     = 6'h21;
  localparam logic [ADDR_W-1:0] ERR      = 6'h22;
  localparam logic [ADDR_W-1:0] MASK     = 6'h23;

  // Word address of the n-th register in a banked window.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic [ADDR_W-1:0] base, input int n);
    return base + ADDR_W'(n);
  endfunction

endpackage

// File: rtl/pio_mailbox_bridge_if.sv
// Avalon-MM slave bus (Nios II side) of the PIO mailbox bridge.
interface pio_mailbox_bridge_if;
  logic [5:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/pio_handshake_channel.sv
// One 4-phase write_switch/wdone handshake channel with per-phase timeout.
module pio_handshake_channel
  import pio_mailbox_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_go,
  input  logic i_wdone,
  output logic o_busy,
  output logic o_write_switch,
  output logic o_done_pulse,
  output logic o_err_pulse
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  chan_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_ws;
  logic             r_done;
  logic             r_err;
  logic             w_timeout;

  // The counter holds cycles already spent in the phase, so the phase lasts exactly TIMEOUT cycles.
  assign w_timeout = TO_EN && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_ws    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (i_go) begin
            if (i_wdone) begin
              r_err <= 1'b1;
            end else begin
              r_state <= ASSERT;
              r_ws    <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        ASSERT: begin
          if (i_wdone) begin
            r_state <= RELEASE;
            r_ws    <= 1'b0;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_ws    <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!i_wdone) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ws    <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_write_switch = r_ws;
  assign o_done_pulse   = r_done;
  assign o_err_pulse    = r_err;

endmodule

// File: rtl/pio_mailbox_bridge.sv
// Avalon-MM mailbox: key slots, per-channel request words, handshake channels, sticky status.
// Optional interrupt logic is built when PIO_MAILBOX_IRQ_EN is defined.
module pio_mailbox_bridge
  import pio_mailbox_pkg::*;
#(
  parameter int NUM_KEYS = 2,
  parameter int KEY_W    = 16,
  parameter int NUM_CH   = 1,
  parameter int REQ_W    = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  pio_mailbox_bridge_if.slave        avs,
  output logic [NUM_KEYS*KEY_W-1:0]  keycode_export,
  output logic [NUM_CH*REQ_W-1:0]    data_request_export,
  output logic [NUM_CH-1:0]          write_switch_export,
  input  logic [NUM_CH-1:0]          wdone_export,
  output logic                       irq
);

  logic [KEY_W-1:0]  r_key [NUM_KEYS];
  logic [REQ_W-1:0]  r_req [NUM_CH];
  logic [NUM_CH-1:0] r_done;
  logic [NUM_CH-1:0] r_err;
  logic [31:0]       r_readdata;
  logic [31:0]       w_rdata;

  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_go;
  logic [NUM_CH-1:0] w_done_set;
  logic [NUM_CH-1:0] w_err_set;
  logic [NUM_CH-1:0] w_done_w1c;
  logic [NUM_CH-1:0] w_err_w1c;
  logic              w_wr_go;

  assign w_wr_go    = avs.avs_write && (avs.avs_address == GO);
  assign w_go       = w_wr_go ? avs.avs_writedata[NUM_CH-1:0] : '0;
  assign w_done_w1c = (avs.avs_write && (avs.avs_address == DONE)) ? avs.avs_writedata[NUM_CH-1:0] : '0;
  assign w_err_w1c  = (avs.avs_write && (avs.avs_address == ERR))  ? avs.avs_writedata[NUM_CH-1:0] : '0;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int k = 0; k < NUM_KEYS; k++) r_key[k] <= '0;
      for (int c = 0; c < NUM_CH; c++)   r_req[c] <= '0;
    end else if (avs.avs_write) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (avs.avs_address == bank_addr(KEY_BASE, k))
          r_key[k] <= avs.avs_writedata[KEY_W-1:0];
      end
      // A busy channel keeps its request word frozen for the fabric.
      for (int c = 0; c < NUM_CH; c++) begin
        if ((avs.avs_address == bank_addr(REQ_BASE, c)) && !w_busy[c])
          r_req[c] <= avs.avs_writedata[REQ_W-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      assign keycode_export[gi*KEY_W +: KEY_W] = r_key[gi];
    end

    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign data_request_export[gi*REQ_W +: REQ_W] = r_req[gi];

      pio_handshake_channel #(
        .TIMEOUT (TIMEOUT)
      ) u_chan (
        .clk            (clk_clk),
        .rst_n          (reset_reset_n),
        .i_go           (w_go[gi]),
        .i_wdone        (wdone_export[gi]),
        .o_busy         (w_busy[gi]),
        .o_write_switch (write_switch_export[gi]),
        .o_done_pulse   (w_done_set[gi]),
        .o_err_pulse    (w_err_set[gi])
      );
    end
  endgenerate

  // A status event landing on the same edge as a W1C keeps the bit set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_done <= '0;
      r_err  <= '0;
    end else begin
      r_done <= (r_done & ~w_done_w1c) | w_done_set;
      r_err  <= (r_err  & ~w_err_w1c)  | w_err_set;
    end
  end

`ifdef PIO_MAILBOX_IRQ_EN
  logic [NUM_CH-1:0] r_mask;
  logic              r_irq;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (avs.avs_write && (avs.avs_address == MASK))
        r_mask <= avs.avs_writedata[NUM_CH-1:0];
      r_irq <= |((r_done | r_err) & r_mask);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (avs.avs_address == bank_addr(KEY_BASE, k))
        w_rdata[KEY_W-1:0] = r_key[k];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (avs.avs_address == bank_addr(REQ_BASE, c))
        w_rdata[REQ_W-1:0] = r_req[c];
    end
    case (avs.avs_address)
      GO:      w_rdata[NUM_CH-1:0] = w_busy;
      DONE:    w_rdata[NUM_CH-1:0] = r_done;
      ERR:     w_rdata[NUM_CH-1:0] = r_err;
`ifdef PIO_MAILBOX_IRQ_EN
      MASK:    w_rdata[NUM_CH-1:0] = r_mask;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      r_readdata <= '0;
    else if (avs.avs_read)
      r_readdata <= w_rdata;
  end

  assign avs.avs_readdata = r_readdata;

endmodule

// File: tb/tb_pio_mailbox_bridge.sv
// Directed bench for pio_mailbox_bridge (4 channels, TIMEOUT=8); read results go through a scoreboard queue.
module tb_pio_mailbox_bridge;
  import pio_mailbox_pkg::*;

`ifdef PIO_MAILBOX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  keycode;
  logic [127:0] dreq;
  logic [3:0]   ws;
  logic [3:0]   wdone = 4'h0;
  logic         irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  pio_mailbox_bridge_if avs_if ();

  pio_mailbox_bridge #(
    .NUM_KEYS (2),
    .KEY_W    (16),
    .NUM_CH   (4),
    .REQ_W    (32),
    .TIMEOUT  (8)
  ) dut (
    .clk_clk             (clk),
    .reset_reset_n       (rst_n),
    .avs                 (avs_if),
    .keycode_export      (keycode),
    .data_request_export (dreq),
    .write_switch_export (ws),
    .wdone_export        (wdone),
    .irq                 (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
    $display("cmp %-14s observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    avs_if.avs_address   = a;
    avs_if.avs_writedata = d;
    avs_if.avs_write     = 1'b1;
    @(negedge clk);
    avs_if.avs_write     = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    avs_if.avs_address = a;
    avs_if.avs_read    = 1'b1;
    @(negedge clk);
    avs_if.avs_read    = 1'b0;
    check(tag, avs_if.avs_readdata, exp_q.pop_front());
  endtask

  int          rise [4] = '{1, 2, 3, 4};
  int          fall [4] = '{3, 5, 7, 9};
  int          n_hi;
  int          guard;
  logic [3:0]  ws_exp;

  initial begin
    avs_if.avs_address   = '0;
    avs_if.avs_read      = 1'b0;
    avs_if.avs_write     = 1'b0;
    avs_if.avs_writedata = '0;
    repeat (3) cyc();
    check("rst_keycode", keycode, 32'h0);
    check("rst_ws", {28'h0, ws}, 32'h0);
    check("rst_readdata", avs_if.avs_readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    cyc();
    rd("rst_busy", GO, 32'h0);

    // Key slots, narrow writes and unmapped reads
    wr(6'h00, 32'h0000_001C);
    wr(6'h01, 32'hABCD_0004);
    check("keycode", keycode, 32'h0004_001C);
    rd("key0_rd", 6'h00, 32'h0000_001C);
    rd("key1_rd", 6'h01, 32'h0000_0004);
    wr(6'h05, 32'h0000_5555);
    rd("key5_rd", 6'h05, 32'h0);
    rd("req5_rd", 6'h15, 32'h0);
    rd("unmapped_rd", 6'h30, 32'h0);
    wr(MASK, 32'h1);
    rd("mask_rd", MASK, {31'h0, IRQ_ON});

    // Normal handshake on channel 0
    wr(REQ_BASE, 32'hDEAD_BEEF);
    check("req0", dreq[31:0], 32'hDEAD_BEEF);
    rd("req0_rd", REQ_BASE, 32'hDEAD_BEEF);
    wr(GO, 32'h1);
    check("ws_rise", {28'h0, ws}, 32'h1);
    cyc();
    cyc();
    check("ws_hold", {28'h0, ws}, 32'h1);
    wdone[0] = 1'b1;
    cyc();
    check("ws_fall", {28'h0, ws}, 32'h0);
    cyc();
    wdone[0] = 1'b0;
    cyc();
    cyc();
    rd("done_set", DONE, 32'h1);
    check("irq_done", {31'h0, irq}, {31'h0, IRQ_ON});
    rd("busy_clr", GO, 32'h0);
    wr(DONE, 32'h1);
    rd("done_w1c", DONE, 32'h0);
    check("irq_clr", {31'h0, irq}, 32'h0);

    // Timeout in ASSERT with a REQ write attempted while busy
    wr(GO, 32'h1);
    n_hi = ws[0] ? 1 : 0;
    wr(REQ_BASE, 32'h1111_2222);
    if (ws[0]) n_hi++;
    check("req_frozen", dreq[31:0], 32'hDEAD_BEEF);
    rd("busy_set", GO, 32'h1);
    if (ws[0]) n_hi++;
    guard = 0;
    while (ws[0] && guard < 20) begin
      cyc();
      guard++;
      if (ws[0]) n_hi++;
    end
    check("timeout_len", n_hi, 32'd8);
    cyc();
    rd("timeout_err", ERR, 32'h1);
    rd("timeout_done", DONE, 32'h0);
    check("irq_err", {31'h0, irq}, {31'h0, IRQ_ON});
    wr(REQ_BASE, 32'h1111_2222);
    check("req_idle_wr", dreq[31:0], 32'h1111_2222);
    wr(ERR, 32'h1);
    rd("err_w1c", ERR, 32'h0);

    // GO while wdone already high
    wdone[0] = 1'b1;
    wr(GO, 32'h1);
    check("go_wdone_ws", {28'h0, ws}, 32'h0);
    cyc();
    rd("go_wdone_err", ERR, 32'h1);
    rd("go_wdone_busy", GO, 32'h0);
    wdone[0] = 1'b0;
    wr(ERR, 32'h1);
    rd("err_w1c2", ERR, 32'h0);

    // Four channels with staggered wdone; W1C of DONE[3] lands on its set edge
    wr(GO, 32'hF);
    check("ws_all", {28'h0, ws}, 32'hF);
    for (int t = 1; t <= 11; t++) begin
      for (int c = 0; c < 4; c++) wdone[c] = (t >= rise[c]) && (t < fall[c]);
      if (t == fall[3] + 1) begin
        avs_if.avs_address   = DONE;
        avs_if.avs_writedata = 32'h9;
        avs_if.avs_write     = 1'b1;
      end else begin
        avs_if.avs_write     = 1'b0;
      end
      cyc();
      for (int c = 0; c < 4; c++) ws_exp[c] = (t < rise[c]);
      check($sformatf("ws_step%0d", t), {28'h0, ws}, {28'h0, ws_exp});
    end
    avs_if.avs_write = 1'b0;
    cyc();
    rd("done_multi", DONE, 32'hE);
    rd("busy_multi", GO, 32'h0);
    rd("err_multi", ERR, 32'h0);
    check("irq_multi", {31'h0, irq}, 32'h0);

    // Reset in the middle of ASSERT
    wr(GO, 32'h1);
    cyc();
    check("pre_rst_ws", {28'h0, ws}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ws", {28'h0, ws}, 32'h0);
    check("mid_rst_key", keycode, 32'h0);
    check("mid_rst_req", dreq[31:0], 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    rd("post_rst_busy", GO, 32'h0);
    rd("post_rst_done", DONE, 32'h0);
    rd("post_rst_err", ERR, 32'h0);
    rd("post_rst_mask", MASK, 32'h0);
    rd("post_rst_key1", 6'h01, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
